// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus request/response types.
// Build option: DBUS_RAND_DELAY_EN adds pseudo-random responder stalls.
package dbus_sram_responder_pkg;

  localparam int DBUS_DATA_W = 64;
  localparam int DBUS_STRB_W = DBUS_DATA_W / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic                   valid;
    logic [63:0]            addr;
    msize_t                 size;
    logic [DBUS_STRB_W-1:0] strobe;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_sram_word_array.sv
// 64-bit word store: one async read port, two byte-strobed write
// ports; the bus port (hi) overrides the preload port (lo) per byte.
module sram_word_array
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DBUS_DATA_W-1:0]   rd_data,
  input  logic                     hi_we,
  input  logic [$clog2(DEPTH)-1:0] hi_idx,
  input  logic [DBUS_STRB_W-1:0]   hi_strb,
  input  logic [DBUS_DATA_W-1:0]   hi_data,
  input  logic                     lo_we,
  input  logic [$clog2(DEPTH)-1:0] lo_idx,
  input  logic [DBUS_DATA_W-1:0]   lo_data
);

  logic [DBUS_DATA_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[rd_idx];

  // Preload lands first; later bus byte writes win on a collision.
  always_ff @(posedge clk) begin
    if (lo_we) begin
      mem_q[lo_idx] <= lo_data;
    end
    if (hi_we) begin
      for (int i = 0; i < DBUS_STRB_W; i++) begin
        if (hi_strb[i]) begin
          mem_q[hi_idx][8*i +: 8] <= hi_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word SRAM with programmable latency.
// Build option: DBUS_RAND_DELAY_EN adds 0..3 LFSR-driven wait cycles.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  dbus_req_t                dreq,
  output dbus_resp_t               dresp,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DBUS_DATA_W-1:0]   ld_data,
  output logic                     busy
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  resp_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DBUS_STRB_W-1:0] strb_q, strb_d;
  logic [DBUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [DBUS_DATA_W-1:0] rd_data;
  logic [1:0]  extra;
  logic [4:0]  load;
  logic        wr_en;
  logic        unused_ok;

  assign unused_ok = ^{dreq.size,
                       dreq.addr[63:3+IW],
                       dreq.addr[2:0]};

`ifdef DBUS_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running stall generator, taps 8,6,5,4.
  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'b00;
`endif

  assign load = 5'(LATENCY - 1) + {3'b000, extra};

  // Next-state: capture, count down, respond once, abort on drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          idx_d   = dreq.addr[3 +: IW];
          strb_d  = dreq.strobe;
          wdata_d = dreq.data;
          cnt_d   = load;
          state_d = (load == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else if (cnt_q <= 5'd1) begin
          cnt_d   = 5'd0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 5'd1;
        end
      end
      RESP: begin
        wr_en   = dreq.valid && (strb_q != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response is live only in RESP while the core still holds valid.
  always_comb begin
    dresp = '0;
    if (state_q == RESP && dreq.valid) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = rd_data;
    end
  end

  assign busy = (state_q != IDLE);

  // Control and captured-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      idx_q   <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
    end
  end

  sram_word_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .rd_idx (idx_q),
    .rd_data(rd_data),
    .hi_we  (wr_en),
    .hi_idx (idx_q),
    .hi_strb(strb_q),
    .hi_data(wdata_q),
    .lo_we  (ld_valid),
    .lo_idx (ld_idx),
    .lo_data(ld_data)
  );

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder (DEPTH=4096, LATENCY=2).
// Honours DBUS_RAND_DELAY_EN when the design is built with it.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int DEPTH = 4096;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        ld_valid;
  logic [11:0] ld_idx;
  logic [63:0] ld_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbus_sram_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dreq    (dreq),
    .dresp   (dresp),
    .ld_valid(ld_valid),
    .ld_idx  (ld_idx),
    .ld_data (ld_data),
    .busy    (busy)
  );

`ifdef DBUS_RAND_DELAY_EN
  logic [7:0] m;
  always @(posedge clk or posedge reset) begin
    if (reset) m <= 8'hA5;
    else       m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end
`endif

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input  logic [63:0] a,
                        input  logic [7:0]  s,
                        input  logic [63:0] d,
                        input  bit          coll,
                        output logic [63:0] rd);
    int lat;
    int exp_lat;
    bit got;
    exp_lat = LAT;
`ifdef DBUS_RAND_DELAY_EN
    exp_lat = LAT + int'(m[1:0]);
`endif
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = MSIZE8;
    dreq.strobe = s;
    dreq.data   = d;
    lat = 0;
    got = 1'b0;
    rd  = '0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (dresp.data_ok) begin
        got = 1'b1;
        rd  = dresp.data;
        chk("addr_ok", 64'(dresp.addr_ok), 64'd1);
        if (coll) begin
          ld_valid = 1'b1;
          ld_idx   = 12'd5;
          ld_data  = 64'hAAAA_AAAA_AAAA_AAAA;
        end
      end else begin
        chk("wait_quiet", 64'(|dresp), 64'd0);
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    tick();
    ld_valid = 1'b0;
    chk("post_quiet", 64'(|dresp), 64'd0);
    dreq.valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    reset    = 1'b1;
    dreq     = '0;
    ld_valid = 1'b0;
    ld_idx   = '0;
    ld_data  = '0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dresp", 64'(|dresp), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    ld_valid = 1'b1;
    ld_idx   = 12'd5;
    ld_data  = 64'h0123_4567_89AB_CDEF;
    tick();
    ld_valid = 1'b0;

    access(64'h28, 8'h00, 64'h0, 1'b0, rd);
    chk("rd5", rd, 64'h0123_4567_89AB_CDEF);

    access(64'h28, 8'h0F, 64'hFFFF_FFFF_1111_2222, 1'b0, rd);
    chk("wr_old", rd, 64'h0123_4567_89AB_CDEF);
    access(64'h28, 8'h00, 64'h0, 1'b0, rd);
    chk("wr_new", rd, 64'h0123_4567_1111_2222);

    access(64'h8000_002B, 8'h00, 64'h0, 1'b0, rd);
    chk("alias", rd, 64'h0123_4567_1111_2222);

    dreq.valid  = 1'b1;
    dreq.addr   = 64'h28;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h0;
    tick();
    chk("abort_busy1", 64'(busy), 64'd1);
    dreq.valid = 1'b0;
    tick();
    chk("abort_busy0", 64'(busy), 64'd0);
    chk("abort_quiet", 64'(|dresp), 64'd0);
    tick();
    access(64'h28, 8'h00, 64'h0, 1'b0, rd);
    chk("abort_mem", rd, 64'h0123_4567_1111_2222);

    access(64'h28, 8'hF0, 64'h1234_5678_9999_9999, 1'b1, rd);
    chk("coll_old", rd, 64'h0123_4567_1111_2222);
    access(64'h28, 8'h00, 64'h0, 1'b0, rd);
    chk("coll_new", rd, 64'h1234_5678_AAAA_AAAA);

    dreq.valid  = 1'b1;
    dreq.addr   = 64'h28;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h0;
    tick();
    chk("rstw_busy1", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_dresp", 64'(|dresp), 64'd0);
    chk("rstw_busy0", 64'(busy), 64'd0);
    dreq.valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    access(64'h28, 8'h00, 64'h0, 1'b0, rd);
    chk("rst_mem", rd, 64'h1234_5678_AAAA_AAAA);

    for (int i = 0; i < 100; i++) begin
      access(64'h28, 8'h00, 64'h0, 1'b0, rd);
      chk("loop_rd", rd, 64'h1234_5678_AAAA_AAAA);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Responder end of the data-bus interface: accepts the core's dbus_req_t, returns dbus_resp_t.
- Backs requests with an internal 64-bit-word SRAM model with programmable latency.
- Used in simulation/FPGA builds as the memory behind the core's dreq/dresp; a preload port initialises contents.

Parameters:
- DEPTH, 4096, number of 64-bit words (power of two); index = addr[3 +: $clog2(DEPTH)], upper bits ignored (wrap).
- LATENCY, 2, cycles from request capture to data_ok (legal range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- dreq  input  dbus_req_t  fields: valid, addr (u64), size (msize_t), strobe (u8), data (u64); strobe==0 means read.
- dresp  output  dbus_resp_t  fields: addr_ok, data_ok, data (u64).
- ld_valid  input  1  preload write enable.
- ld_idx  input  $clog2(DEPTH)  preload word index.
- ld_data  input  64  preload word.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async): FSM=IDLE, counter=0, dresp all zero, busy=0. SRAM contents are not cleared.
- FSM IDLE:
  - dreq.valid=1: capture addr index, strobe, data; load counter=LATENCY-1; go WAIT (LATENCY>1) or RESP (LATENCY==1).
- FSM WAIT:
  - Decrement counter; at counter==0 go RESP.
  - If dreq.valid drops, abort to IDLE with no write.
- FSM RESP (exactly one cycle), if dreq.valid still 1:
  - Assert addr_ok=1, data_ok=1.
  - data = SRAM word read at captured index (pre-write value for writes).
  - Commit write: byte lane i updated iff strobe[i].
  - Go IDLE.
- FSM RESP, if dreq.valid=0: abort, no write, dresp stays 0, go IDLE.
- dresp is 0 in all states except RESP; data_ok is a single-cycle pulse.
- Latency: request seen in IDLE at cycle T → data_ok at cycle T+LATENCY.
- Throughput: the next request is capturable at T+LATENCY+1, so back-to-back accesses have a one-cycle IDLE gap.
- The core holds dreq stable until data_ok. Changes mid-WAIT are ignored; captured values are used.
- size is not used for alignment: responder always operates on the aligned 8-byte word, with strobe selecting bytes.
- Misaligned addr[2:0] is ignored.
- Preload:
  - ld_valid writes ld_data to ld_idx at any state.
  - On a same-cycle, same-index collision with an RESP write commit, the bus write wins on strobed bytes; preload wins on other bytes.
- Reset mid-operation: pending access is discarded, no write commits, FSM=IDLE next cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro DBUS_RAND_DELAY_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advances every cycle.
  - On capture, adds LFSR[1:0] (0..3) extra WAIT cycles to LATENCY.
  - Exercises the core's stall logic.
- Undefined: latency exactly LATENCY; no LFSR logic instantiated.

Decomposition:
- Shared package (common): dbus_req_t, dbus_resp_t, msize_t, strobe width, DBUS_DATA_W=64.
- Local enum resp_state_t {IDLE, WAIT, RESP} stays inside the module.
- One natural sub-module, sram_word_array: DEPTH×64 storage, one combinational read port, two byte-strobed write ports with fixed priority.
  - The responder FSM instantiates it.

Test Plan:
- Preload idx 5 = 64'h0123_4567_89AB_CDEF; read addr 0x28 at T with LATENCY=2 → data_ok=1 only at T+2, data=64'h0123_4567_89AB_CDEF, dresp=0 at T+1 and T+3.
- Write addr 0x28, strobe 8'h0F, data 64'hFFFF_FFFF_1111_2222 → following read returns 64'h0123_4567_1111_2222.
- dreq.valid dropped at T+1 during a write (LATENCY=3) → no data_ok, memory unchanged, busy=0 by T+2.
- Assert reset during WAIT → dresp=0 immediately (async), FSM IDLE, preloaded word intact.
- addr 0x8000_0028 with DEPTH=4096 → aliases to idx 5, returns the same word as 0x28.
- DBUS_RAND_DELAY_EN defined, 100 reads → every data_ok arrives within LATENCY..LATENCY+3 cycles of capture; first latency deterministic from seed 8'hA5.
